pwm_fade_bank: RTL and testbench

PWM_FADE_BANK -- requirements
Module: pwm_fade_bank

---
 rtl/pwm_fade_bank.sv | 171 +++++++++++++++++
 tb/tb_pwm_fade_bank.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_fade_bank.sv
`default_nettype none
// ============================================================================
// Module   : pwm_fade_bank
// Purpose  : NCH-channel PWM bank with register-mapped duty and linear fading.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_fade_bank #(
    parameter int NCH = 8,
    parameter int W   = 8,
    parameter int PSW = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           wen,
    input  logic [7:0]     addr,
    input  logic [15:0]    wdata,
    output logic [15:0]    rdata,
    output logic [NCH-1:0] pwm,
    output logic           period_start
);

    localparam logic [W-1:0] c_ramp_max   = '1;
    localparam logic [2:0]   c_pg_target  = 3'b000;
    localparam logic [2:0]   c_pg_current = 3'b001;
    localparam logic [7:0]   c_a_ctrl     = 8'h40;
    localparam logic [7:0]   c_a_prescale = 8'h41;
    localparam logic [7:0]   c_a_status   = 8'h42;

    logic [W-1:0]   ramp_q,     ramp_d;
    logic [PSW-1:0] fcnt_q,     fcnt_d;
    logic [1:0]     ctrl_q,     ctrl_d;
    logic [PSW-1:0] prescale_q, prescale_d;
    logic [W-1:0]   target_q  [NCH];
    logic [W-1:0]   target_d  [NCH];
    logic [W-1:0]   current_q [NCH];
    logic [W-1:0]   current_d [NCH];
    logic [W-1:0]   duty_q    [NCH];
    logic [W-1:0]   duty_d    [NCH];
    logic [NCH-1:0] pwm_q,      pwm_d;

    logic           w_en;
    logic           w_inv;
    logic           w_ramp_top;
    logic           w_wrap;
    logic           w_step;
    logic           w_busy;
    logic [NCH-1:0] w_wr_tgt;
    logic [NCH-1:0] w_wr_cur;
    logic           w_unused;

    assign w_en       = ctrl_q[0];
    assign w_inv      = ctrl_q[1];
    assign w_ramp_top = (ramp_q == c_ramp_max);
    assign w_wrap     = w_en && w_ramp_top;
    // ">=" rather than "==" so lowering PRESCALE below a running count
    // steps at the next wrap instead of rolling the whole counter over.
    assign w_step     = w_wrap && (fcnt_q >= prescale_q);
    assign w_unused   = ^wdata;

    always_comb begin
        w_wr_tgt = '0;
        w_wr_cur = '0;
        w_busy   = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            w_wr_tgt[i] = wen && (addr[7:5] == c_pg_target)  && (addr[4:0] == 5'(i));
            w_wr_cur[i] = wen && (addr[7:5] == c_pg_current) && (addr[4:0] == 5'(i));
            w_busy      = w_busy || (current_q[i] != target_q[i]);
        end
    end

    always_comb begin
        ramp_d     = w_en ? ramp_q + 1'b1 : '0;
        fcnt_d     = fcnt_q;
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        pwm_d      = '0;

        if (w_wrap) begin
            fcnt_d = w_step ? '0 : fcnt_q + 1'b1;
        end
        if (wen && (addr == c_a_ctrl)) begin
            ctrl_d = wdata[1:0];
        end
        if (wen && (addr == c_a_prescale)) begin
            prescale_d = wdata[PSW-1:0];
        end

        for (int i = 0; i < NCH; i++) begin
            target_d[i]  = target_q[i];
            current_d[i] = current_q[i];
            duty_d[i]    = duty_q[i];

            if (w_step) begin
                if (current_q[i] < target_q[i]) begin
                    current_d[i] = current_q[i] + 1'b1;
                end else if (current_q[i] > target_q[i]) begin
                    current_d[i] = current_q[i] - 1'b1;
                end
            end
            // Register writes come last so they override a coincident step.
            if (w_wr_tgt[i]) begin
                target_d[i] = wdata[W-1:0];
            end
            if (w_wr_cur[i]) begin
                current_d[i] = wdata[W-1:0];
                target_d[i]  = wdata[W-1:0];
            end

            if (w_ramp_top) begin
                duty_d[i] = current_q[i];
            end

            if (w_en) begin
                pwm_d[i] = ((ramp_q < duty_q[i]) || (duty_q[i] == c_ramp_max)) ^ w_inv;
            end else begin
                pwm_d[i] = w_inv;
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (addr == c_a_ctrl) begin
            rdata = {14'b0, ctrl_q};
        end else if (addr == c_a_prescale) begin
            rdata = 16'(prescale_q);
        end else if (addr == c_a_status) begin
            rdata = {15'b0, w_busy};
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if ((addr[7:5] == c_pg_target) && (addr[4:0] == 5'(i))) begin
                    rdata = 16'(target_q[i]);
                end
                if ((addr[7:5] == c_pg_current) && (addr[4:0] == 5'(i))) begin
                    rdata = 16'(current_q[i]);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ramp_q     <= '0;
            fcnt_q     <= '0;
            ctrl_q     <= '0;
            prescale_q <= '0;
            pwm_q      <= '0;
            for (int i = 0; i < NCH; i++) begin
                target_q[i]  <= '0;
                current_q[i] <= '0;
                duty_q[i]    <= '0;
            end
        end else begin
            ramp_q     <= ramp_d;
            fcnt_q     <= fcnt_d;
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            pwm_q      <= pwm_d;
            for (int i = 0; i < NCH; i++) begin
                target_q[i]  <= target_d[i];
                current_q[i] <= current_d[i];
                duty_q[i]    <= duty_d[i];
            end
        end
    end

    assign pwm          = pwm_q;
    assign period_start = w_en && (ramp_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_pwm_fade_bank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pwm_fade_bank
// Purpose  : Directed self-checking bench for pwm_fade_bank (NCH=8, W=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_fade_bank;

    localparam int NCH = 8;
    localparam int W   = 8;
    localparam int PSW = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           wen;
    logic [7:0]     addr;
    logic [15:0]    wdata;
    logic [15:0]    rdata;
    logic [NCH-1:0] pwm;
    logic           period_start;

    int             n_vec = 0;
    int             n_err = 0;
    int             cnt [NCH];
    int             ps_cnt;
    logic [NCH-1:0] s64;
    logic [NCH-1:0] s65;

    always #5 clk = ~clk;

    pwm_fade_bank #(.NCH(NCH), .W(W), .PSW(PSW)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wen          (wen),
        .addr         (addr),
        .wdata        (wdata),
        .rdata        (rdata),
        .pwm          (pwm),
        .period_start (period_start)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_vec++;
        if (obs !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_wr(input logic [7:0] a, input logic [15:0] d);
        addr  = a;
        wdata = d;
        wen   = 1'b1;
        tick();
        wen   = 1'b0;
    endtask

    task automatic reg_chk(input string tag, input logic [7:0] a, input logic [15:0] want);
        addr = a;
        #1;
        check(tag, 32'(rdata), 32'(want));
    endtask

    // Leaves the bench one step after the edge on which ramp became 0.
    task automatic wait_ps();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!period_start && n < 1000);
        if (!period_start) check("period_start timeout", 32'(period_start), 32'd1);
    endtask

    // One full period of samples starting at ramp = 0; ends at the next ramp = 0.
    task automatic measure();
        for (int c = 0; c < NCH; c++) cnt[c] = 0;
        ps_cnt = 0;
        for (int j = 0; j < 256; j++) begin
            for (int c = 0; c < NCH; c++) if (pwm[c]) cnt[c]++;
            if (period_start) ps_cnt++;
            if (j == 64) s64 = pwm;
            if (j == 65) s65 = pwm;
            tick();
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c2;
        rst_n = 1'b0;
        wen   = 1'b0;
        addr  = 8'h00;
        wdata = 16'h0000;
        #1;
        check("reset pwm", 32'(pwm), 32'h0);
        check("reset period_start", 32'(period_start), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        reg_chk("reset CTRL", 8'h40, 16'h0);
        reg_chk("reset PRESCALE", 8'h41, 16'h0);
        reg_chk("reset STATUS", 8'h42, 16'h0);
        reg_chk("reset CURRENT7", 8'h27, 16'h0);
        check("idle period_start", 32'(period_start), 32'h0);

        // 25% duty on channel 0
        reg_wr(8'h40, 16'h0001);
        reg_wr(8'h20, 16'h0040);
        reg_chk("TARGET0 follows CURRENT0 write", 8'h00, 16'h0040);
        reg_chk("STATUS after jump", 8'h42, 16'h0);
        wait_ps();
        measure();
        check("ch0 high count 0x40", 32'(cnt[0]), 32'd64);
        check("ch0 high at ramp 63", 32'(s64[0]), 32'd1);
        check("ch0 low at ramp 64", 32'(s65[0]), 32'd0);
        check("ch1 idle count", 32'(cnt[1]), 32'd0);
        check("period_start pulses per period", 32'(ps_cnt), 32'd1);

        // Full-scale and zero duty, plain and inverted
        reg_wr(8'h23, 16'h00FF);
        wait_ps(); measure(); measure();
        check("ch3 duty FF", 32'(cnt[3]), 32'd256);
        reg_wr(8'h23, 16'h0000);
        wait_ps(); measure(); measure();
        check("ch3 duty 0", 32'(cnt[3]), 32'd0);
        reg_wr(8'h40, 16'h0003);
        wait_ps(); measure(); measure();
        check("ch3 duty 0 inverted", 32'(cnt[3]), 32'd256);
        check("ch0 duty 0x40 inverted", 32'(cnt[0]), 32'd192);
        reg_wr(8'h23, 16'h00FF);
        wait_ps(); measure(); measure();
        check("ch3 duty FF inverted", 32'(cnt[3]), 32'd0);
        reg_wr(8'h40, 16'h0001);

        // Fade up 0 -> 5 with PRESCALE=1, then down 5 -> 2
        wait_ps();
        reg_wr(8'h41, 16'h0001);
        reg_wr(8'h01, 16'h0005);
        reg_chk("CURRENT1 unchanged by TARGET write", 8'h21, 16'h0);
        reg_chk("BUSY after TARGET write", 8'h42, 16'h1);
        for (int k = 1; k <= 12; k++) begin
            wait_ps();
            reg_chk($sformatf("fade up CURRENT1 k=%0d", k), 8'h21,
                    16'((k / 2 > 5) ? 5 : k / 2));
            reg_chk($sformatf("fade up BUSY k=%0d", k), 8'h42, (k < 10) ? 16'h1 : 16'h0);
        end
        reg_wr(8'h01, 16'h0002);
        for (int k = 1; k <= 8; k++) begin
            wait_ps();
            reg_chk($sformatf("fade down CURRENT1 k=%0d", k), 8'h21,
                    16'((5 - k / 2 < 2) ? 2 : 5 - k / 2));
            reg_chk($sformatf("fade down BUSY k=%0d", k), 8'h42, (k < 6) ? 16'h1 : 16'h0);
        end
        reg_wr(8'h41, 16'h0000);

        // Mid-period CURRENT write lands only at the next wrap
        wait_ps();
        c2 = 0;
        for (int j = 0; j < 256; j++) begin
            if (pwm[2]) c2++;
            if (j == 16) begin
                addr  = 8'h22;
                wdata = 16'h0080;
                wen   = 1'b1;
            end
            tick();
            wen = 1'b0;
        end
        check("ch2 unchanged in write period", 32'(c2), 32'd0);
        measure();
        check("ch2 duty 0x80 next period", 32'(cnt[2]), 32'd128);

        // CURRENT write on the very edge of a fade step
        reg_wr(8'h04, 16'h0020);
        reg_wr(8'h05, 16'h0020);
        wait_ps();
        reg_chk("CURRENT5 first step", 8'h25, 16'h0001);
        for (int j = 0; j < 255; j++) tick();
        reg_wr(8'h24, 16'h0008);
        check("write landed on wrap", 32'(period_start), 32'd1);
        reg_chk("CURRENT4 write beats step", 8'h24, 16'h0008);
        reg_chk("TARGET4 write beats step", 8'h04, 16'h0008);
        reg_chk("CURRENT5 still steps", 8'h25, 16'h0002);

        // Disable mid-fade with INV set, then re-enable
        for (int j = 0; j < 50; j++) tick();
        reg_wr(8'h40, 16'h0002);
        tick(); tick();
        check("disabled pwm = INV", 32'(pwm), 32'hFF);
        ps_cnt = 0;
        for (int j = 0; j < 600; j++) begin
            if (period_start) ps_cnt++;
            tick();
        end
        check("no period_start while disabled", 32'(ps_cnt), 32'd0);
        check("disabled pwm held", 32'(pwm), 32'hFF);
        reg_chk("CURRENT5 frozen", 8'h25, 16'h0002);
        reg_chk("BUSY while frozen", 8'h42, 16'h1);
        reg_wr(8'h27, 16'h0033);
        reg_chk("write accepted while disabled", 8'h27, 16'h0033);
        reg_wr(8'h40, 16'h0001);
        check("period_start on enable", 32'(period_start), 32'd1);
        wait_ps();
        reg_chk("CURRENT5 resumes", 8'h25, 16'h0003);
        measure();
        check("ch7 duty 0x33 after enable", 32'(cnt[7]), 32'd51);
        check("ch3 duty FF after enable", 32'(cnt[3]), 32'd256);

        // Unmapped addresses, then reset mid-period mid-fade
        for (int j = 0; j < 100; j++) tick();
        reg_chk("unmapped 0x7F", 8'h7F, 16'h0);
        reg_chk("unmapped CURRENT8", 8'h28, 16'h0);
        reg_wr(8'h08, 16'h0055);
        reg_chk("unmapped TARGET8 reads 0", 8'h08, 16'h0);
        reg_chk("TARGET0 not aliased", 8'h00, 16'h0040);
        check("ch3 high before reset", 32'(pwm[3]), 32'd1);
        rst_n = 1'b0;
        #1;
        check("pwm cleared by async reset", 32'(pwm), 32'h0);
        check("period_start cleared by reset", 32'(period_start), 32'h0);
        reg_chk("CTRL after reset", 8'h40, 16'h0);
        reg_chk("PRESCALE after reset", 8'h41, 16'h0);
        reg_chk("STATUS after reset", 8'h42, 16'h0);
        reg_chk("TARGET5 after reset", 8'h05, 16'h0);
        reg_chk("CURRENT5 after reset", 8'h25, 16'h0);
        reg_chk("CURRENT0 after reset", 8'h20, 16'h0);
        reg_chk("unmapped 0x7F in reset", 8'h7F, 16'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check("pwm after reset release", 32'(pwm), 32'h0);
        reg_wr(8'h40, 16'h0001);
        check("ramp restarts at 0", 32'(period_start), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
